// File: rtl/bp_clint_ctrl.sv
// Core-local interruptor (CLINT) controller.
// Holds the per-core software-interrupt bits (msip), the per-core timer
// compare registers (mtimecmp) and one shared, prescaled 64-bit mtime counter.
// It serves one load/store at a time: a valid/ready request handshake is
// followed by a valid/yumi response handshake. It drives one software
// interrupt line and one timer interrupt line for each core.
//
// Address map inside the 64 KiB device window at 0x0030_0000:
//   [15:14]=00 msip[idx]     (idx = addr[13:3])
//   [15:14]=01 mtimecmp[idx]
//   [15:14]=10 mtime         (addr[13:3] must be 0)
//   [15:14]=11 unmapped
// Every access must be 8-byte aligned.

module bp_clint_ctrl #(
  parameter int num_core_p    = 2,
  parameter int paddr_width_p = 40,
  parameter int timer_div_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [63:0]              req_data_i,

  output logic                     resp_v_o,
  output logic [63:0]              resp_data_o,
  output logic                     resp_err_o,
  input  logic                     resp_yumi_i,

  output logic [num_core_p-1:0]    software_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o
);

  // Width of the register index field, addr[13:3].
  localparam int idx_w = 11;
  // The prescaler needs at least one bit, even when timer_div_p is 1.
  localparam int ps_w  = (timer_div_p > 1) ? $clog2(timer_div_p) : 1;
  localparam logic [ps_w-1:0]            ps_last  = ps_w'(timer_div_p - 1);
  localparam logic [paddr_width_p-17:0]  dev_base = (paddr_width_p - 16)'(16'h0030);
  // The core count is held one bit wider than the index, so 2048 fits.
  localparam logic [idx_w:0]             num_core = (idx_w + 1)'(num_core_p);

  typedef enum logic {
    ready_s = 1'b0,
    resp_s  = 1'b1
  } state_e;

  state_e state_q, state_n;

  // Decode of the request address.
  logic [1:0]       region;
  logic [idx_w-1:0] idx;
  logic             dev_hit;
  logic             aligned;
  logic             idx_ok;
  logic             sel_mipi;
  logic             sel_cmp;
  logic             sel_mtime;
  logic             decode_err;
  logic [63:0]      load_data;

  logic             accept;
  logic             wr_en;

  // Architectural state.
  logic [num_core_p-1:0] msip;
  logic [63:0]           mtimecmp [num_core_p];
  logic [63:0]           mtime;
  logic [ps_w-1:0]       prescaler;
  logic                  tick;
  logic [num_core_p-1:0] timer_irq_q;

  // Captured response.
  logic [63:0]           resp_data_q;
  logic                  resp_err_q;

  // A request can be taken only while the FSM is in READY. Any req_v_i seen
  // in RESP is left pending for the requester to keep presenting.
  assign accept = req_v_i && (state_q == ready_s);
  assign wr_en  = accept && req_w_i;

  // State register: an asynchronous reset returns the FSM to READY, so any
  // pending response is dropped immediately.
  // NOTE: every flop uses <= so all registers sample the same pre-edge values;
  // using = here would make the result depend on statement and block order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ready_s;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state: accept in READY, then hold RESP until the response is consumed.
  // NOTE: state_n gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ready_s: if (req_v_i)     state_n = resp_s;
      resp_s:  if (resp_yumi_i) state_n = ready_s;
      default:                  state_n = ready_s;
    endcase
  end

  // Handshake outputs are a pure decode of the current state.
  always_comb begin
    req_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_q)
      ready_s: req_ready_o = 1'b1;
      resp_s:  resp_v_o    = 1'b1;
      default: req_ready_o = 1'b0;
    endcase
  end

  // Address decode and load-data mux. A load of mtime sees the pre-update value.
  always_comb begin
    region     = req_addr_i[15:14];
    idx        = req_addr_i[13:3];
    dev_hit    = (req_addr_i[paddr_width_p-1:16] == dev_base);
    aligned    = (req_addr_i[2:0] == 3'b000);
    idx_ok     = ({1'b0, idx} < num_core);
    sel_mipi   = dev_hit && aligned && (region == 2'b00) && idx_ok;
    sel_cmp    = dev_hit && aligned && (region == 2'b01) && idx_ok;
    sel_mtime  = dev_hit && aligned && (region == 2'b10) && (idx == '0);
    decode_err = !(sel_mipi || sel_cmp || sel_mtime);

    load_data = '0;
    for (int i = 0; i < num_core_p; i++) begin
      if (idx == idx_w'(i)) begin
        if (sel_mipi) load_data = {63'b0, msip[i]};
        if (sel_cmp)  load_data = mtimecmp[i];
      end
    end
    if (sel_mtime) load_data = mtime;
  end

  // Response capture on acceptance. Stores and illegal addresses return 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (accept) begin
      resp_data_q <= req_w_i ? 64'b0 : load_data;
      resp_err_q  <= decode_err;
    end
  end

  assign resp_data_o = resp_data_q;
  assign resp_err_o  = resp_err_q;

  // Software-interrupt bits: only bit 0 of the store data is kept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      msip <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (wr_en && sel_mipi && (idx == idx_w'(i))) msip[i] <= req_data_i[0];
      end
    end
  end

  // Timer compare registers. They reset to all ones, so no timer interrupt
  // fires until software programs a compare value.
  // NOTE: this array needs a reset value, so it is built from resettable flops
  // and cannot map to RAM. Keep it small, or drop the reset if it is ever
  // moved into a memory macro.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_core_p; i++) mtimecmp[i] <= '1;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (wr_en && sel_cmp && (idx == idx_w'(i))) mtimecmp[i] <= req_data_i;
      end
    end
  end

  assign tick = (prescaler == ps_last);

  // mtime and its prescaler. A store to mtime takes priority over the tick
  // and restarts the prescaler. mtime wraps naturally at 2^64.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mtime     <= '0;
      prescaler <= '0;
    end else if (wr_en && sel_mtime) begin
      mtime     <= req_data_i;
      prescaler <= '0;
    end else if (tick) begin
      mtime     <= mtime + 64'd1;
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Timer interrupts are registered from the current register values, so
  // they trail any change to mtime or mtimecmp by one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_irq_q <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) timer_irq_q[i] <= (mtime >= mtimecmp[i]);
    end
  end

  assign timer_irq_o    = timer_irq_q;
  assign software_irq_o = msip;

endmodule

// File: doc/bp_clint_ctrl.md
Name: bp_clint_ctrl

Overview:
- Memory-mapped core-local interruptor controller for the clint device window at 0x0030_0000.
- Owns the per-core software-interrupt bits (mipi), the per-core timer compare registers (mtimecmp) and a shared 64b mtime counter.
- Serves one load/store request at a time over a valid/ready request and valid/yumi response handshake.
- Drives the software and timer interrupt lines for each core.

Parameters:
- num_core_p, 2, number of cores served; legal range 1..2048.
- paddr_width_p, 40, physical address width.
- timer_div_p, 8, clk_i cycles per mtime tick; must be >= 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous and active-high
- req_v_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_w_i  in  1  1=store, 0=load
- req_addr_i  in  paddr_width_p  byte address
- req_data_i  in  64  store data
- resp_v_o  out  1  response valid
- resp_data_o  out  64  load data; 0 for stores
- resp_err_o  out  1  request decoded to an illegal address
- resp_yumi_i  in  1  response consumed
- software_irq_o  out  num_core_p  per-core msip
- timer_irq_o  out  num_core_p  per-core mtime >= mtimecmp

Behaviour:
- Reset values (held while reset_i=1):
  - FSM=READY.
  - resp_v_o=0, resp_data_o=0, resp_err_o=0.
  - msip=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, mtime=0, prescaler=0.
  - software_irq_o=0, timer_irq_o=0.
  - req_ready_o=1, because it is a combinational decode of state READY.
- FSM has two states:
  - READY: req_ready_o=1, resp_v_o=0. On req_v_i=1 the request is accepted in that cycle: the store is committed at the clock edge, load data and err are registered, and the FSM goes to RESP.
  - RESP: req_ready_o=0, resp_v_o=1, and resp_data_o/resp_err_o are stable. If resp_yumi_i=1, go to READY; otherwise stay in RESP.
- Latency and throughput: response is valid the cycle after acceptance. Peak throughput is one request per 2 cycles.
- Async reset in RESP drops resp_v_o immediately. The pending response is lost.
- Address decode: a = req_addr_i.
  - Error conditions: a[paddr_width_p-1:16] != 16'h0030, or a[2:0] != 0.
  - a[15:14]=00: mipi. Index idx=a[13:3]; idx >= num_core_p -> error.
  - a[15:14]=01: mtimecmp. idx=a[13:3]; idx >= num_core_p -> error.
  - a[15:14]=10: mtime. a[13:3] must be 0, else error.
  - a[15:14]=11: error.
- Error handling: a store has no effect; load data=0; resp_err_o=1 for the response.
- Register semantics:
  - mipi: a store writes msip[idx]=req_data_i[0]. A load returns {63'b0, msip[idx]}.
  - mtimecmp: full 64b read/write.
  - mtime: full 64b read/write. A load returns the value before this cycle's update.
- mtime counter:
  - prescaler counts 0..timer_div_p-1 and wraps to 0.
  - mtime increments by 1 on the cycle the prescaler wraps. With timer_div_p=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
  - A store to mtime loads req_data_i and clears the prescaler. It wins over a simultaneous increment.
- Interrupt outputs:
  - timer_irq_o[i] is registered as (mtime >= mtimecmp[i]), unsigned, computed from current register values. It therefore lags a register change by 1 cycle.
  - software_irq_o[i] = msip[i], taken directly from the flop.
- Inputs on an unaccepted cycle are ignored:
  - req_v_i while in RESP.
  - resp_yumi_i while in READY.

Test Plan:
- Reset, then store 64'h1 to 0x0030_0008, yumi on resp:
  - req_ready_o=1 after reset.
  - resp_v_o=1 the next cycle with resp_err_o=0.
  - software_irq_o=2'b10.
  - A load of 0x0030_0008 returns 1.
- timer_div_p=8, store mtimecmp[0] at 0x0030_4000 = 3:
  - timer_irq_o[0] rises exactly 1 cycle after mtime reaches 3, i.e. about 24 cycles after reset.
  - Storing 64'hFFFF_FFFF_FFFF_FFFF to the same address clears it 1 cycle later.
- Store mtime at 0x0030_8000 = 64'hFFFF_FFFF_FFFF_FFFF and wait 8 cycles:
  - mtime wraps to 0.
  - A load of 0x0030_8000 returns a small value, not 2^64-1.
- Error decodes, each must give resp_err_o=1, data 0, and no state change:
  - Load 0x0030_0010 (idx 2 >= num_core_p).
  - Store 0x0030_4004 (misaligned).
  - Load 0x0030_C000 (region 11).
  - Load 0x0020_0000 (wrong device).
- Backpressure:
  - Hold resp_yumi_i=0 for 5 cycles while req_v_i stays high. resp_data_o is stable, req_ready_o=0, and no second store commits.
  - After yumi, the held request is accepted the following cycle.
- Assert reset_i asynchronously mid-RESP:
  - resp_v_o drops without a clock edge.
  - msip=0, mtimecmp=all ones, mtime=0.
